// File: rtl/mini68k_sr_ctrl_pkg.sv
// Shared SR field positions, reserved-bit mask, FSM encoding and SR sanitiser.
package mini68k_pkg;
  localparam int SR_T      = 15;
  localparam int SR_S      = 13;
  localparam int SR_IM_HI  = 10;
  localparam int SR_IM_LO  = 8;
  localparam int SR_CCR_HI = 4;

  // Bits 14, 12:11 and 7:5 are unimplemented and always read as zero.
  localparam logic [15:0] SR_RSVD_MASK = 16'h58E0;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Clears reserved bits; drops T when tracing is not built in.
  function automatic logic [15:0] sr_clean(input logic [15:0] v, input logic trace_en);
    logic [15:0] r;
    r = v & ~SR_RSVD_MASK;
    if (!trace_en) r[SR_T] = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/mini68k_sr_ctrl_if.sv
// Decoder/ALU/exception-controller side of the SR controller.
interface mini68k_sr_ctrl_if #(parameter int NEST_DEPTH = 8);
  localparam int CW = $clog2(NEST_DEPTH) + 1;

  logic [4:0]    ccr_in;
  logic [4:0]    ccr_mask;
  logic          ccr_we;
  logic [15:0]   sr_in;
  logic          sr_we;
  logic          exc_req;
  logic          exc_is_int;
  logic [2:0]    exc_level;
  logic          rte_req;
  logic [2:0]    irq_level;

  logic [15:0]   sr_out;
  logic [4:0]    ccr_out;
  logic          supervisor;
  logic          trace;
  logic [2:0]    int_mask;
  logic          irq_take;
  logic          exc_ack;
  logic          priv_viol;
  logic          rte_err;
  logic          halted;
  logic [CW-1:0] nest_cnt;

  modport master (
    output ccr_in, ccr_mask, ccr_we, sr_in, sr_we, exc_req, exc_is_int, exc_level,
           rte_req, irq_level,
    input  sr_out, ccr_out, supervisor, trace, int_mask, irq_take, exc_ack, priv_viol,
           rte_err, halted, nest_cnt
  );

  modport slave (
    input  ccr_in, ccr_mask, ccr_we, sr_in, sr_we, exc_req, exc_is_int, exc_level,
           rte_req, irq_level,
    output sr_out, ccr_out, supervisor, trace, int_mask, irq_take, exc_ack, priv_viol,
           rte_err, halted, nest_cnt
  );
endinterface

// File: rtl/mini68k_sr_stack.sv
// LIFO of saved SRs for nested exception return.
module mini68k_sr_stack #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   din,
  output logic [15:0]   top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] top_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = AW'(count - CW'(1));
  assign top     = mem[top_idx];

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) mem[count[AW-1:0]] <= din;
  end

  // Occupancy; push and pop are mutually exclusive at the caller.
  always_ff @(posedge clk) begin
    if (!rst_n)                count <= '0;
    else if (push && !full)    count <= count + CW'(1);
    else if (pop && !empty)    count <= count - CW'(1);
  end
endmodule

// File: rtl/mini68k_sr_ctrl.sv
// Status register with exception entry/RTE sequencing, IRQ gating and double-fault halt.
module mini68k_sr_ctrl import mini68k_pkg::*; #(
  parameter int          NEST_DEPTH = 8,
  parameter logic [15:0] SR_RESET   = 16'h2700,
  parameter bit          TRACE_EN   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  mini68k_sr_ctrl_if.slave  bus
);
  localparam int CW = $clog2(NEST_DEPTH) + 1;

  logic [15:0]   sr, sr_nxt, sr_ccr, stk_top;
  logic [0:0]    state, state_nxt;
  logic          nmi_prev;
  logic          push, pop, stk_full, stk_empty;
  logic          ack_q, viol_q, rerr_q;
  logic          ack_nxt, viol_nxt, rerr_nxt;
  logic [CW-1:0] nest;

  mini68k_sr_stack #(.DEPTH(NEST_DEPTH), .CW(CW)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sr_ccr),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (nest)
  );

  // Prioritised next-SR selection: entry > RTE > SR write > CCR write.
  always_comb begin
    sr_ccr = sr;
    if (bus.ccr_we)
      sr_ccr[SR_CCR_HI:0] = (sr[SR_CCR_HI:0] & ~bus.ccr_mask) | (bus.ccr_in & bus.ccr_mask);
    sr_nxt    = sr;
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    ack_nxt   = 1'b0;
    viol_nxt  = 1'b0;
    rerr_nxt  = 1'b0;
    if (state == ST_RUN) begin
      if (bus.exc_req) begin
        if (stk_full) begin
          state_nxt = ST_HALT;
        end else begin
          // Save the SR including the flags of the ALU op retiring this cycle.
          push         = 1'b1;
          ack_nxt      = 1'b1;
          sr_nxt       = sr_ccr;
          sr_nxt[SR_T] = 1'b0;
          sr_nxt[SR_S] = 1'b1;
          if (bus.exc_is_int) sr_nxt[SR_IM_HI:SR_IM_LO] = bus.exc_level;
        end
      end else if (bus.rte_req) begin
        if (stk_empty) begin
          rerr_nxt = 1'b1;
        end else begin
          pop    = 1'b1;
          sr_nxt = stk_top;
          if (!TRACE_EN) sr_nxt[SR_T] = 1'b0;
        end
      end else if (bus.sr_we && sr[SR_S]) begin
        sr_nxt = sr_clean(bus.sr_in, TRACE_EN);
      end else begin
        // A refused SR write does not block the flags update of the same cycle.
        viol_nxt = bus.sr_we;
        sr_nxt   = sr_ccr;
      end
    end
  end

  // State, SR and registered one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr       <= SR_RESET;
      state    <= ST_RUN;
      nmi_prev <= 1'b0;
      ack_q    <= 1'b0;
      viol_q   <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      sr       <= sr_nxt;
      state    <= state_nxt;
      nmi_prev <= (bus.irq_level == 3'd7);
      ack_q    <= ack_nxt;
      viol_q   <= viol_nxt;
      rerr_q   <= rerr_nxt;
    end
  end

  assign bus.sr_out     = sr;
  assign bus.ccr_out    = sr[SR_CCR_HI:0];
  assign bus.supervisor = sr[SR_S];
  assign bus.trace      = sr[SR_T];
  assign bus.int_mask   = sr[SR_IM_HI:SR_IM_LO];
  assign bus.exc_ack    = ack_q;
  assign bus.priv_viol  = viol_q;
  assign bus.rte_err    = rerr_q;
  assign bus.halted     = (state == ST_HALT);
  assign bus.nest_cnt   = nest;
  // Level 7 bypasses the mask, but only on its rising edge.
  assign bus.irq_take   = (state == ST_RUN) &&
                          ((bus.irq_level > sr[SR_IM_HI:SR_IM_LO]) ||
                           (bus.irq_level == 3'd7 && !nmi_prev));
endmodule
